ram_port_arbiter: RTL and testbench
===================================

// Module: ram_port_arbiter
// PURPOSE
//  Shares the single RAM controller port (SDRAM on ULX3S, PSRAM on Blue Whale) between instruction fetch (I) and
//  load/store (D) requesters of the risc_p pipeline. It grants one requester per transaction, holds the grant until
//  the RAM acks, and returns ack/data to the owner only.
//  Bounded anti-starvation for I and a per-transaction watchdog that returns an error on a hung RAM.
// PARAMETERS
//  ADDR_W        32   address width of requester and RAM ports
//  MAX_D_BURST   4    consecutive D grants allowed while I is pending before I is forced
//  TIMEOUT_CYC   256  cycles after RAM stb without ack before abort with error (>=2)
// PORTS
//  clk_i          in   1       system clock
//  rst_n_i        in   1       asynchronous active-low reset
//  i_stb_i        in   1       I request; held until i_ack_o or i_err_o
//  i_addr_i       in   ADDR_W  I word address (read only)
//  i_ack_o        out  1       I transaction done, i_data_o valid this cycle
//  i_err_o        out  1       I transaction aborted by watchdog
//  i_data_o       out  32      I read data
//  d_stb_i        in   1       D request; held until d_ack_o or d_err_o
//  d_we_i         in   1       D write enable
//  d_sel_i        in   4       D byte lanes
//  d_addr_i       in   ADDR_W  D address
//  d_data_i       in   32      D write data
//  d_ack_o        out  1       D transaction done, d_data_o valid on reads
//  d_err_o        out  1       D transaction aborted by watchdog
//  d_data_o       out  32      D read data
//  ram_stb_o      out  1       request to RAM controller (registered)
//  ram_we_o       out  1       write enable (registered)
//  ram_sel_o      out  4       byte lanes (registered; 4'hF for I)
//  ram_addr_o     out  ADDR_W  address (registered)
//  ram_data_o     out  32      write data (registered)
//  ram_ack_i      in   1       RAM transaction complete, ram_data_i valid
//  ram_data_i     in   32      RAM read data
// BEHAVIOUR
//  Reset (async, immediate): state=IDLE, all outputs 0, d_streak=0, wdog=0.
//  States: IDLE, OWN_I, OWN_D, DRAIN.
//  IDLE: D and I both pending -> D wins unless d_streak==MAX_D_BURST, then I wins. One pending -> it wins.
//   On the grant edge, latch the winner's addr/we/sel/data into ram_*_o, set ram_stb_o=1, enter OWN_x, and clear wdog.
//   Latency is one cycle: a request seen in IDLE at edge N gives ram_stb_o=1 after edge N.
//  d_streak: +1 (saturating) on a D grant while i_stb_i=1; cleared on any I grant and whenever i_stb_i=0 in IDLE.
//  OWN_x: ram_stb_o held. On ram_ack_i=1, x_ack_o=1 and x_data_o=ram_data_i combinationally in that cycle.
//   At the same edge, clear ram_stb_o and go to IDLE. The non-owner's ack/err stay 0.
//   I writes are impossible: ram_we_o=0 and ram_sel_o=4'hF for I.
//  Back-to-back: the cycle after ack is spent in IDLE, so the minimum gap between RAM stbs is one cycle.
//  Requester drops stb before ack (flush/trap): stay in OWN_x with ram_stb_o held. When ram_ack_i arrives, suppress x_ack_o, drop ram_stb_o and go to IDLE.
//  Watchdog: wdog counts in OWN_x. At wdog==TIMEOUT_CYC-1 without ack: x_err_o=1 for one cycle (if x_stb_i still high), drop ram_stb_o and enter DRAIN.
//  DRAIN: wait for one late ram_ack_i (discard its data), then go to IDLE. If ram_ack_i coincides with the timeout cycle, treat it as a normal ack with no err.
//  ram_ack_i in IDLE is ignored. Requester signals are sampled only in IDLE; changes during OWN_x have no effect.
//  x_ack_o and x_err_o are never both 1.
// TESTING
//  1 Reset: rst_n_i=0 mid OWN_D -> all outputs 0 immediately; the next i_stb_i after release is granted in 1 cycle.
//  2 Single I read @0x0000_0100 with RAM ack after 3 cycles returning 0xDEADBEEF:
//    ram_stb_o rises 1 cycle after i_stb_i; i_ack_o=1 with i_data_o=0xDEADBEEF; d_ack_o stays 0.
//  3 Collision: i_stb_i and d_stb_i both held with MAX_D_BURST=4 -> grant order D,D,D,D,I,D,D,D,D,I.
//  4 D write: sel=4'b0011, data=0x1234_5678 -> ram_we_o=1, ram_sel_o=4'b0011, ram_data_o=0x1234_5678; d_ack_o after RAM ack.
//  5 Timeout with TIMEOUT_CYC=8 and no RAM ack: d_err_o pulses exactly 8 cycles after ram_stb_o rose.
//    A late ram_ack_i is absorbed in DRAIN; the next I request is served normally.
//  6 Cancel: i_stb_i dropped 1 cycle after grant -> ram_stb_o held to ram_ack_i, i_ack_o never asserted, back in IDLE.

Source files
------------

// File: rtl/ram_port_arbiter.sv
// Shares one RAM controller port between the instruction-fetch (I) and load/store (D) requesters,
// with bounded anti-starvation for I and a per-transaction watchdog against a hung RAM.
module ram_port_arbiter #(
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned MAX_D_BURST = 4,
    parameter int unsigned TIMEOUT_CYC = 256
) (
    input  logic              clk_i,
    input  logic              rst_n_i,

    input  logic              i_stb_i,
    input  logic [ADDR_W-1:0] i_addr_i,
    output logic              i_ack_o,
    output logic              i_err_o,
    output logic [31:0]       i_data_o,

    input  logic              d_stb_i,
    input  logic              d_we_i,
    input  logic [3:0]        d_sel_i,
    input  logic [ADDR_W-1:0] d_addr_i,
    input  logic [31:0]       d_data_i,
    output logic              d_ack_o,
    output logic              d_err_o,
    output logic [31:0]       d_data_o,

    output logic              ram_stb_o,
    output logic              ram_we_o,
    output logic [3:0]        ram_sel_o,
    output logic [ADDR_W-1:0] ram_addr_o,
    output logic [31:0]       ram_data_o,
    input  logic              ram_ack_i,
    input  logic [31:0]       ram_data_i
);

    localparam int unsigned STREAK_W = $clog2(MAX_D_BURST + 1);
    localparam int unsigned WDOG_W   = $clog2(TIMEOUT_CYC);

    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_D_BURST);
    localparam logic [WDOG_W-1:0]   WDOG_LAST  = WDOG_W'(TIMEOUT_CYC - 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_OWN_I = 2'd1;
    localparam logic [1:0] ST_OWN_D = 2'd2;
    localparam logic [1:0] ST_DRAIN = 2'd3;

    logic [1:0]          r_state;
    logic [STREAK_W-1:0] r_d_streak;
    logic [WDOG_W-1:0]   r_wdog;

    logic                r_ram_stb;
    logic                r_ram_we;
    logic [3:0]          r_ram_sel;
    logic [ADDR_W-1:0]   r_ram_addr;
    logic [31:0]         r_ram_data;

    logic                w_grant_d;
    logic                w_grant_i;
    logic                w_own_i;
    logic                w_own_d;
    logic                w_timeout;

    // D normally wins a collision; once it has won MAX_D_BURST times in a row while I waited, I is forced.
    assign w_grant_d = d_stb_i && (!i_stb_i || (r_d_streak != STREAK_MAX));
    assign w_grant_i = i_stb_i && !w_grant_d;

    assign w_own_i   = (r_state == ST_OWN_I);
    assign w_own_d   = (r_state == ST_OWN_D);
    assign w_timeout = (w_own_i || w_own_d) && !ram_ack_i && (r_wdog == WDOG_LAST);

    // A requester that dropped its strobe mid-transaction gets neither ack nor err.
    assign i_ack_o  = w_own_i && ram_ack_i && i_stb_i;
    assign d_ack_o  = w_own_d && ram_ack_i && d_stb_i;
    assign i_err_o  = w_own_i && w_timeout && i_stb_i;
    assign d_err_o  = w_own_d && w_timeout && d_stb_i;
    assign i_data_o = i_ack_o ? ram_data_i : '0;
    assign d_data_o = d_ack_o ? ram_data_i : '0;

    assign ram_stb_o  = r_ram_stb;
    assign ram_we_o   = r_ram_we;
    assign ram_sel_o  = r_ram_sel;
    assign ram_addr_o = r_ram_addr;
    assign ram_data_o = r_ram_data;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state    <= ST_IDLE;
            r_d_streak <= '0;
            r_wdog     <= '0;
            r_ram_stb  <= 1'b0;
            r_ram_we   <= 1'b0;
            r_ram_sel  <= '0;
            r_ram_addr <= '0;
            r_ram_data <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_grant_d) begin
                        r_state    <= ST_OWN_D;
                        r_wdog     <= '0;
                        r_ram_stb  <= 1'b1;
                        r_ram_we   <= d_we_i;
                        r_ram_sel  <= d_sel_i;
                        r_ram_addr <= d_addr_i;
                        r_ram_data <= d_data_i;
                        r_d_streak <= i_stb_i ? (r_d_streak + STREAK_W'(1)) : '0;
                    end else if (w_grant_i) begin
                        r_state    <= ST_OWN_I;
                        r_wdog     <= '0;
                        r_ram_stb  <= 1'b1;
                        r_ram_we   <= 1'b0;
                        r_ram_sel  <= '1;
                        r_ram_addr <= i_addr_i;
                        r_ram_data <= '0;
                        r_d_streak <= '0;
                    end else begin
                        r_d_streak <= '0;
                    end
                end
                ST_OWN_I, ST_OWN_D: begin
                    if (ram_ack_i) begin
                        r_state   <= ST_IDLE;
                        r_ram_stb <= 1'b0;
                    end else if (r_wdog == WDOG_LAST) begin
                        r_state   <= ST_DRAIN;
                        r_ram_stb <= 1'b0;
                    end else begin
                        r_wdog <= r_wdog + WDOG_W'(1);
                    end
                end
                ST_DRAIN: begin
                    if (ram_ack_i) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state   <= ST_IDLE;
                    r_ram_stb <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter: a transaction-level model checked every cycle,
// plus hand-computed expectations for each scenario.
module tb_ram_port_arbiter;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned MAX_D  = 4;
    localparam int unsigned TO     = 8;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              i_stb, i_ack, i_err;
    logic [ADDR_W-1:0] i_addr;
    logic [31:0]       i_data;
    logic              d_stb, d_we, d_ack, d_err;
    logic [3:0]        d_sel;
    logic [ADDR_W-1:0] d_addr;
    logic [31:0]       d_wdata, d_rdata;
    logic              ram_stb, ram_we, ram_ack;
    logic [3:0]        ram_sel;
    logic [ADDR_W-1:0] ram_addr;
    logic [31:0]       ram_wdata, ram_rdata;

    always #5 clk = ~clk;

    ram_port_arbiter #(
        .ADDR_W      (ADDR_W),
        .MAX_D_BURST (MAX_D),
        .TIMEOUT_CYC (TO)
    ) dut (
        .clk_i      (clk),
        .rst_n_i    (rst_n),
        .i_stb_i    (i_stb),
        .i_addr_i   (i_addr),
        .i_ack_o    (i_ack),
        .i_err_o    (i_err),
        .i_data_o   (i_data),
        .d_stb_i    (d_stb),
        .d_we_i     (d_we),
        .d_sel_i    (d_sel),
        .d_addr_i   (d_addr),
        .d_data_i   (d_wdata),
        .d_ack_o    (d_ack),
        .d_err_o    (d_err),
        .d_data_o   (d_rdata),
        .ram_stb_o  (ram_stb),
        .ram_we_o   (ram_we),
        .ram_sel_o  (ram_sel),
        .ram_addr_o (ram_addr),
        .ram_data_o (ram_wdata),
        .ram_ack_i  (ram_ack),
        .ram_data_i (ram_rdata)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // ---------------- transaction-level model ----------------
    typedef enum {M_FREE, M_I, M_D, M_DRAIN} owner_t;
    owner_t            m_owner;
    int                m_age;
    int                m_dwins;
    logic              m_stb, m_we;
    logic [3:0]        m_sel;
    logic [ADDR_W-1:0] m_addr;
    logic [31:0]       m_data;
    bit                m_glog[$];

    initial begin
        logic e_iack, e_ierr, e_dack, e_derr;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                m_owner = M_FREE; m_age = 0; m_dwins = 0;
                m_stb = 0; m_we = 0; m_sel = 0; m_addr = 0; m_data = 0;
            end
            e_iack = (m_owner == M_I) && ram_ack && i_stb;
            e_dack = (m_owner == M_D) && ram_ack && d_stb;
            e_ierr = (m_owner == M_I) && !ram_ack && i_stb && (m_age == TO - 1);
            e_derr = (m_owner == M_D) && !ram_ack && d_stb && (m_age == TO - 1);
            check("cyc_i_side", {i_ack, i_err, i_data}, {e_iack, e_ierr, (e_iack ? ram_rdata : 32'h0)});
            check("cyc_d_side", {d_ack, d_err, d_rdata}, {e_dack, e_derr, (e_dack ? ram_rdata : 32'h0)});
            check("cyc_ram_ctl", {ram_stb, ram_we, ram_sel}, {m_stb, m_we, m_sel});
            check("cyc_ram_addr", ram_addr, m_addr);
            check("cyc_ram_data", ram_wdata, m_data);
            if (rst_n) begin
                case (m_owner)
                    M_FREE: begin
                        if (d_stb && !(i_stb && m_dwins >= MAX_D)) begin
                            m_owner = M_D; m_age = 0; m_stb = 1;
                            m_we = d_we; m_sel = d_sel; m_addr = d_addr; m_data = d_wdata;
                            m_dwins = i_stb ? m_dwins + 1 : 0;
                            m_glog.push_back(1'b1);
                        end else if (i_stb) begin
                            m_owner = M_I; m_age = 0; m_stb = 1;
                            m_we = 0; m_sel = 4'hF; m_addr = i_addr; m_data = 0;
                            m_dwins = 0;
                            m_glog.push_back(1'b0);
                        end else begin
                            m_dwins = 0;
                        end
                    end
                    M_I, M_D: begin
                        if (ram_ack) begin
                            m_owner = M_FREE; m_stb = 0;
                        end else if (m_age == TO - 1) begin
                            m_owner = M_DRAIN; m_stb = 0;
                        end else begin
                            m_age++;
                        end
                    end
                    default: if (ram_ack) m_owner = M_FREE;
                endcase
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_stb(input string name);
        for (int k = 0; k < 20 && !ram_stb; k++) tick();
        if (!ram_stb) check(name, ram_stb, 1'b1);
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        logic [9:0] dut_order, mdl_order;
        int         q0, err_idx, stb_cycles;

        rst_n = 0; i_stb = 0; i_addr = 0; d_stb = 0; d_we = 0; d_sel = 0;
        d_addr = 0; d_wdata = 0; ram_ack = 0; ram_rdata = 0;
        repeat (2) @(posedge clk);
        #3 rst_n = 1;
        tick();
        check("reset_ram_outs", {ram_stb, ram_we, ram_sel, ram_addr}, 64'h0);
        check("reset_acks", {i_ack, i_err, d_ack, d_err}, 4'b0000);

        // single I read, RAM ack three cycles later
        i_addr = 32'h0000_0100; i_stb = 1;
        check("t2_no_stb_yet", ram_stb, 1'b0);
        tick();
        check("t2_stb_latency1", ram_stb, 1'b1);
        check("t2_addr", ram_addr, 32'h0000_0100);
        check("t2_i_we_sel", {ram_we, ram_sel}, 5'b0_1111);
        repeat (3) tick();
        ram_ack = 1; ram_rdata = 32'hDEAD_BEEF;
        #1;
        check("t2_i_ack", i_ack, 1'b1);
        check("t2_i_data", i_data, 32'hDEAD_BEEF);
        check("t2_d_ack_quiet", d_ack, 1'b0);
        tick();
        ram_ack = 0; i_stb = 0;
        check("t2_stb_dropped", ram_stb, 1'b0);

        // collision: both held for ten transactions
        q0 = m_glog.size();
        i_addr = 32'h0000_0100; d_addr = 32'h0000_0200; d_sel = 4'hF; d_we = 0;
        i_stb = 1; d_stb = 1;
        dut_order = '0;
        for (int g = 0; g < 10; g++) begin
            wait_stb("t3_grant_timeout");
            dut_order[9 - g] = (ram_addr == 32'h0000_0200);
            ram_ack = 1; ram_rdata = 32'(g);
            tick();
            ram_ack = 0;
        end
        i_stb = 0; d_stb = 0;
        check("t3_dut_order", dut_order, 10'b11110_11110);
        mdl_order = '0;
        if (m_glog.size() < q0 + 10) check("t3_model_log_len", m_glog.size(), q0 + 10);
        else for (int g = 0; g < 10; g++) mdl_order[9 - g] = m_glog[q0 + g];
        check("t3_model_order", mdl_order, 10'b11110_11110);
        tick();

        // D write
        d_addr = 32'h0000_0400; d_sel = 4'b0011; d_wdata = 32'h1234_5678; d_we = 1; d_stb = 1;
        tick();
        check("t4_ctl", {ram_stb, ram_we, ram_sel}, 6'b1_1_0011);
        check("t4_wdata", ram_wdata, 32'h1234_5678);
        check("t4_addr", ram_addr, 32'h0000_0400);
        tick();
        ram_ack = 1; ram_rdata = 32'h0;
        #1;
        check("t4_acks", {d_ack, i_ack}, 2'b10);
        tick();
        ram_ack = 0; d_stb = 0; d_we = 0; d_wdata = 0;
        tick();

        // watchdog timeout, late ack absorbed, then normal I service
        d_addr = 32'h0000_0500; d_sel = 4'hF; d_stb = 1;
        tick();
        err_idx = -1; stb_cycles = 0;
        for (int k = 0; k < 20; k++) begin
            if (!ram_stb) break;
            stb_cycles++;
            if (d_err && err_idx < 0) err_idx = k;
            tick();
        end
        check("t5_err_cycle", err_idx, 7);
        check("t5_stb_cycles", stb_cycles, 8);
        check("t5_err_one_shot", d_err, 1'b0);
        d_stb = 0;
        repeat (2) tick();
        i_addr = 32'h0000_0700; i_stb = 1;
        tick();
        check("t5_no_grant_in_drain", ram_stb, 1'b0);
        ram_ack = 1; ram_rdata = 32'hBAD0_BAD0;
        #1;
        check("t5_late_ack_absorbed", {i_ack, d_ack, i_err, d_err}, 4'b0000);
        tick();
        ram_ack = 0;
        check("t5_idle_after_drain", ram_stb, 1'b0);
        tick();
        check("t5_i_granted", {ram_stb, ram_addr}, {1'b1, 32'h0000_0700});
        ram_ack = 1; ram_rdata = 32'hCAFE_F00D;
        #1;
        check("t5_i_served", {i_ack, i_data}, {1'b1, 32'hCAFE_F00D});
        tick();
        ram_ack = 0; i_stb = 0;

        // cancel: I drops its strobe one cycle after grant
        tick();
        i_addr = 32'h0000_0600; i_stb = 1;
        tick();
        check("t6_granted", ram_stb, 1'b1);
        tick();
        i_stb = 0;
        repeat (3) begin
            tick();
            check("t6_stb_held", ram_stb, 1'b1);
        end
        ram_ack = 1; ram_rdata = 32'h0000_0077;
        #1;
        check("t6_ack_suppressed", {i_ack, i_data}, 33'h0);
        tick();
        ram_ack = 0;
        check("t6_stb_dropped", ram_stb, 1'b0);
        tick();
        check("t6_stays_idle", ram_stb, 1'b0);

        // stray RAM ack while idle
        ram_ack = 1; ram_rdata = 32'h5555_AAAA;
        #1;
        check("idle_ack_ignored", {i_ack, d_ack}, 2'b00);
        tick();
        ram_ack = 0;

        // async reset in the middle of a D transaction
        d_addr = 32'h0000_0300; d_sel = 4'hF; d_stb = 1;
        tick();
        check("t1_own_d", ram_stb, 1'b1);
        #2 rst_n = 0;
        #1;
        check("t1_reset_immediate", {ram_stb, ram_we, ram_sel, ram_addr}, 64'h0);
        check("t1_reset_acks", {i_ack, i_err, d_ack, d_err}, 4'b0000);
        d_stb = 0;
        @(posedge clk);
        #3 rst_n = 1;
        tick();
        i_addr = 32'h0000_0800; i_stb = 1;
        tick();
        check("t1_grant_after_reset", {ram_stb, ram_addr}, {1'b1, 32'h0000_0800});
        ram_ack = 1; ram_rdata = 32'h0BAD_F00D;
        #1;
        check("t1_i_ack", {i_ack, i_data}, {1'b1, 32'h0BAD_F00D});
        tick();
        ram_ack = 0; i_stb = 0;
        repeat (3) tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
